// File: rtl/tl_arbiter_ctrl.sv
// tl_arbiter_ctrl: link FSM, threshold latch and pop arbiter for the transaction-layer FIFO bank.
// Define TL_ARB_RR_EN for round-robin grants; otherwise the lowest non-empty FIFO wins.
module tl_arbiter_ctrl #(
  parameter int DATA_W   = 12,
  parameter int N_REQ    = 4,
  parameter int UMBRAL_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRAL_W-1:0]     umbral_AF_in,
  input  logic [UMBRAL_W-1:0]     umbral_AE_in,
  input  logic [N_REQ-1:0]        fifo_empty,
  input  logic [N_REQ*DATA_W-1:0] fifo_data,
  input  logic [N_REQ-1:0]        fifo_error,
  input  logic                    out_almost_full,
  output logic [N_REQ-1:0]        pop,
  output logic                    push_out,
  output logic [DATA_W-1:0]       data_out,
  output logic [UMBRAL_W-1:0]     umbral_AF_out,
  output logic [UMBRAL_W-1:0]     umbral_AE_out,
  output logic [3:0]              state,
  output logic                    idle
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_INIT   = 4'd1,
    S_IDLE   = 4'd2,
    S_ACTIVE = 4'd3,
    S_ERROR  = 4'd4
  } st_t;
  st_t st, st_nx;
  logic err, gnt_v;
  logic [N_REQ-1:0] elig;
  logic [PW-1:0] gnt, idx;
  logic [DATA_W-1:0] words [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_word
    assign words[i] = fifo_data[i*DATA_W +: DATA_W];
  end
`ifdef TL_ARB_RR_EN
  logic [PW-1:0] ptr;
  always_ff @(posedge clk) begin
    if (!reset) ptr <= '0;
    else if (gnt_v) ptr <= PW'((int'(gnt) + 1) % N_REQ);
  end
`else
  localparam logic [PW-1:0] ptr = '0;
`endif
  assign err  = |fifo_error;
  // a grant is withheld while any FIFO reports an error so no word is popped and then lost
  assign elig = (reset && st == S_ACTIVE && !out_almost_full && !err) ? ~fifo_empty : '0;
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (elig[idx]) begin
        gnt_v = 1'b1;
        gnt   = idx;
      end
    end
  end
  assign pop = gnt_v ? N_REQ'(1) << gnt : '0;
  always_comb begin
    st_nx = st;
    unique case (st)
      S_RESET:  st_nx = S_INIT;
      S_INIT:   st_nx = err ? S_ERROR : init ? S_INIT : S_IDLE;
      S_IDLE:   st_nx = err ? S_ERROR : init ? S_INIT : ~&fifo_empty ? S_ACTIVE : S_IDLE;
      S_ACTIVE: st_nx = err ? S_ERROR : &fifo_empty ? S_IDLE : S_ACTIVE;
      default:  st_nx = S_ERROR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st            <= S_RESET;
      push_out      <= 1'b0;
      data_out      <= '0;
      umbral_AF_out <= '0;
      umbral_AE_out <= '0;
    end else begin
      st       <= st_nx;
      push_out <= gnt_v;
      if (gnt_v) data_out <= words[gnt];
      if (st == S_INIT) begin
        umbral_AF_out <= umbral_AF_in;
        umbral_AE_out <= umbral_AE_in;
      end
    end
  end
  assign state = st;
  assign idle  = st == S_IDLE;
endmodule

// File: tb/tb_tl_arbiter_ctrl.sv
// tb_tl_arbiter_ctrl: queue-based reference model of the upstream FIFOs and link controller.
module tb_tl_arbiter_ctrl;
  localparam int DW = 12, N = 4, UW = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, init, out_almost_full, push_out, idle;
  logic [UW-1:0] umbral_AF_in, umbral_AE_in, umbral_AF_out, umbral_AE_out;
  logic [N-1:0] fifo_empty, fifo_error, pop;
  logic [N*DW-1:0] fifo_data;
  logic [DW-1:0] data_out;
  logic [3:0] state;

  tl_arbiter_ctrl #(.DATA_W(DW), .N_REQ(N), .UMBRAL_W(UW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_AF_in(umbral_AF_in), .umbral_AE_in(umbral_AE_in),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_error(fifo_error),
    .out_almost_full(out_almost_full), .pop(pop), .push_out(push_out),
    .data_out(data_out), .umbral_AF_out(umbral_AF_out), .umbral_AE_out(umbral_AE_out),
    .state(state), .idle(idle)
  );

  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] q [N][$];
  logic [DW-1:0] got_q [$];
  int m_st = 0, m_ptr = 0, g;
  bit m_push = 0;
  logic [DW-1:0] m_data = '0;
  logic [UW-1:0] m_af = '0, m_ae = '0;
  bit rst_v = 0, init_v = 0, oaf_v = 0;
  logic [N-1:0] err_v = '0;
  logic [UW-1:0] af_v = '0, ae_v = '0;

  task automatic tick();
    bit any;
    @(negedge clk);
    reset = rst_v; init = init_v; out_almost_full = oaf_v; fifo_error = err_v;
    umbral_AF_in = af_v; umbral_AE_in = ae_v;
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = q[i].size() == 0;
      fifo_data[i*DW +: DW] = q[i].size() != 0 ? q[i][0] : '0;
    end
    g = -1;
    if (rst_v && m_st == 3 && !oaf_v && err_v == 0)
      for (int k = 0; k < N; k++)
        if (g < 0 && q[(m_ptr + k) % N].size() != 0) g = (m_ptr + k) % N;
    #1;
    check("state", state, m_st);
    check("idle", idle, m_st == 2);
    check("push_out", push_out, m_push);
    check("data_out", data_out, m_data);
    check("umbral_AF", umbral_AF_out, m_af);
    check("umbral_AE", umbral_AE_out, m_ae);
    check("pop", pop, g < 0 ? 64'd0 : 64'd1 << g);
    if (push_out) got_q.push_back(data_out);
    @(posedge clk);
    any = 0;
    for (int i = 0; i < N; i++) any |= q[i].size() != 0;
    if (!rst_v) begin
      m_st = 0; m_ptr = 0; m_push = 0; m_data = '0; m_af = '0; m_ae = '0;
    end else begin
      m_push = 0;
      case (m_st)
        0: m_st = 1;
        1: begin m_af = af_v; m_ae = ae_v; m_st = err_v != 0 ? 4 : init_v ? 1 : 2; end
        2: m_st = err_v != 0 ? 4 : init_v ? 1 : any ? 3 : 2;
        3: begin
          if (g >= 0) begin
            m_push = 1;
            m_data = q[g].pop_front();
`ifdef TL_ARB_RR_EN
            m_ptr = (g + 1) % N;
`endif
          end
          m_st = err_v != 0 ? 4 : any ? 3 : 2;
        end
        default: m_st = 4;
      endcase
    end
  endtask

  task automatic bring_up();
    rst_v = 1; init_v = 1;
    repeat (2) tick();
    init_v = 0;
    repeat (2) tick();
  endtask

  initial begin
    logic [DW-1:0] exp_w [$];
    reset = 0; init = 0; out_almost_full = 0; fifo_error = '0;
    umbral_AF_in = '0; umbral_AE_in = '0; fifo_empty = '1; fifo_data = '0;
    repeat (2) tick();
    rst_v = 1; init_v = 1; af_v = 3'd6; ae_v = 3'd2;
    repeat (2) tick();
    init_v = 0;
    repeat (2) tick();
    #1;
    check("init_state", state, 2);
    check("init_af", umbral_AF_out, 6);
    check("init_ae", umbral_AE_out, 2);
    for (int i = 0; i < N; i++) q[i] = '{DW'(12'h100 + i), DW'(12'h200 + i)};
    got_q.delete();
    repeat (14) tick();
    check("rr_count", got_q.size(), 8);
    for (int p = 0; p < 8 && p < got_q.size(); p++)
`ifdef TL_ARB_RR_EN
      check("rr_word", got_q[p], 12'h100 * (1 + p / 4) + p % 4);
`else
      check("fp_word", got_q[p], 12'h100 * (1 + p % 2) + p / 2);
`endif
    #1;
    check("rr_idle", state, 2);
    for (int i = 0; i < N; i++) q[i] = '{DW'(12'h300 + i), DW'(12'h310 + i), DW'(12'h320 + i)};
    got_q.delete();
    exp_w.delete();
    for (int i = 0; i < N; i++) for (int j = 0; j < 3; j++) exp_w.push_back(DW'(12'h300 + 16 * j + i));
    repeat (4) tick();
    oaf_v = 1;
    repeat (3) tick();
    oaf_v = 0;
    repeat (14) tick();
    got_q.sort();
    exp_w.sort();
    check("bp_count", got_q.size(), 12);
    for (int p = 0; p < 12 && p < got_q.size(); p++) check("bp_word", got_q[p], exp_w[p]);
    for (int i = 0; i < N; i++) q[i] = '{DW'(12'h400 + i), DW'(12'h410 + i), DW'(12'h420 + i)};
    repeat (3) tick();
    err_v = 4'b0100;
    tick();
    err_v = '0;
    #1;
    check("err_state", state, 4);
    repeat (4) tick();
    rst_v = 0;
    tick();
    #1;
    check("err_reset", state, 0);
    bring_up();
    repeat (2) tick();
    rst_v = 0;
    tick();
    #1;
    check("mid_push", push_out, 0);
    check("mid_data", data_out, 0);
    check("mid_state", state, 0);
    bring_up();
    for (int i = 0; i < N; i++) q[i].delete();
    q[0] = '{12'h500, 12'h501, 12'h502};
    q[3] = '{12'h503, 12'h504, 12'h505};
    repeat (10) tick();
    for (int n = 0; n < 2000; n++) begin
      rst_v = $urandom_range(0, 200) != 0;
      init_v = $urandom_range(0, 15) == 0;
      oaf_v = $urandom_range(0, 3) == 0;
      err_v = $urandom_range(0, 150) == 0 ? N'(1) << $urandom_range(0, N - 1) : '0;
      af_v = UW'($urandom_range(0, 7));
      ae_v = UW'($urandom_range(0, 7));
      tick();
      for (int i = 0; i < N; i++)
        if (q[i].size() < 4 && $urandom_range(0, 2) == 0) q[i].push_back(DW'($urandom_range(0, 4095)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
